// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and the baud divider helper.
// Also intended for the matching RX block.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  function automatic int div_calc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready byte stream feeding the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and flags the last clock of each bit.
module uart_baud_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign bit_end = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (clr || bit_end)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a one-deep holding register; consecutive frames
// leave no idle clock between the last stop bit and the next start bit.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 125_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_cfg_if.slave s,
  output logic         tx,
  output logic         busy,
  output logic         done
);
  // state    | meaning
  // S_IDLE   | line high, waiting for the holding register to fill
  // S_START  | start bit (low)
  // S_DATA   | payload bits, LSB first
  // S_PARITY | parity bit (skipped when PARITY is none)
  // S_STOP   | stop bit(s), high; the last one may chain into S_START

  localparam int DIV = div_calc(CLK_HZ, BAUD);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
  localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 tx_d, done_d;
  logic                 load, accept, bit_end, baud_clr;

  assign accept    = s.s_valid && !hold_full;
  assign s.s_ready = !hold_full;
  assign busy      = (state_q != S_IDLE);
  assign baud_clr  = (state_q == S_IDLE);

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (baud_clr),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_q    <= s.s_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    done_d    = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (hold_full) load = 1'b1;
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        tx_d = par_q;
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            if (hold_full) load = 1'b1;
            else           state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // parity is fixed at load time from the whole word, before any shifting
    if (load) begin
      state_d   = S_START;
      shift_d   = hold_q;
      par_d     = (PAR_MODE == PAR_ODD) ? ~^hold_q : ^hold_q;
      bit_cnt_d = '0;
    end
  end

  // tx and done are registered from the current state, so both trail the FSM by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      tx        <= 1'b1;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      tx        <= tx_d;
      done      <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations (8N1, 8E1, 8O1, 7N2) at DIV=10, checked every
// cycle against a frame-schedule model, plus directed frame captures and corner sequences.
module tb_uart_tx_cfg;
  localparam int NI   = 4;
  localparam int DIV  = 10;
  localparam int MAXC = 20000;
  localparam int DB [NI] = '{8, 8, 8, 7};
  localparam int PA [NI] = '{0, 2, 1, 0};
  localparam int SB [NI] = '{1, 1, 1, 2};

  logic clk, rst_n;
  int   cyc = 0;
  int   n_vec = 0, n_err = 0;
  logic [8:0] d [NI];
  logic       v [NI];
  logic [NI-1:0] r, tx, busy, done;
  logic [3:0] exp_vec [NI][MAXC];   // {tx, done, busy, s_ready} per cycle
  int   next_free [NI];
  int   last_done [NI];
  logic [8:0] sbuf [NI][64];
  int   head [NI], tail [NI];
  bit   fill_ones;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

  assign if0.s_data = d[0][7:0]; assign if0.s_valid = v[0]; assign r[0] = if0.s_ready;
  assign if1.s_data = d[1][7:0]; assign if1.s_valid = v[1]; assign r[1] = if1.s_ready;
  assign if2.s_data = d[2][7:0]; assign if2.s_valid = v[2]; assign r[2] = if2.s_ready;
  assign if3.s_data = d[3][6:0]; assign if3.s_valid = v[3]; assign r[3] = if3.s_ready;

  uart_tx_cfg #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .s(if0), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
  uart_tx_cfg #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .s(if1), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
  uart_tx_cfg #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .s(if2), .tx(tx[2]), .busy(busy[2]), .done(done[2]));
  uart_tx_cfg #(.CLK_HZ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .s(if3), .tx(tx[3]), .busy(busy[3]), .done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Schedule a whole frame accepted at edge k: start at max(k+2, end of previous frame).
  task automatic model_accept(input int i, input int data, input int k);
    int t0, len, ones, pb, bitv;
    len  = 1 + DB[i] + ((PA[i] != 0) ? 1 : 0) + SB[i];
    t0   = (k + 2 > next_free[i]) ? k + 2 : next_free[i];
    ones = 0;
    for (int b = 0; b < DB[i]; b++) ones += (data >> b) & 1;
    pb = (PA[i] == 1) ? ((ones % 2 == 0) ? 1 : 0) : (ones % 2);
    for (int c = k; c < t0 - 1; c++) if (c < MAXC) exp_vec[i][c][0] = 1'b0;
    for (int c = t0 - 1; c <= t0 + len * DIV - 2; c++) if (c < MAXC) exp_vec[i][c][1] = 1'b1;
    for (int b = 0; b < len; b++) begin
      if (b == 0)                             bitv = 0;
      else if (b <= DB[i])                    bitv = (data >> (b - 1)) & 1;
      else if (PA[i] != 0 && b == DB[i] + 1)  bitv = pb;
      else                                    bitv = 1;
      for (int j = 0; j < DIV; j++)
        if (t0 + b * DIV + j < MAXC) exp_vec[i][t0 + b * DIV + j][3] = bitv[0];
    end
    if (t0 + len * DIV - 1 < MAXC) exp_vec[i][t0 + len * DIV - 1][2] = 1'b1;
    next_free[i] = t0 + len * DIV;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int c = cyc + 1; c < MAXC; c++) exp_vec[i][c] = 4'b1001;
      next_free[i] = 0;
      head[i] = tail[i];
    end
  endtask

  task automatic push(input int i, input logic [8:0] data);
    sbuf[i][tail[i] % 64] = data & 9'((1 << DB[i]) - 1);
    tail[i]++;
  endtask

  // Per-cycle check, then drive the next handshake cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (cyc < MAXC)
        chk($sformatf("line%0d", i), 16'({tx[i], done[i], busy[i], r[i]}), 16'(exp_vec[i][cyc]));
      if (done[i]) last_done[i] = cyc;
      if (!rst_n) begin
        v[i] = 1'b0;
      end else begin
        if (head[i] != tail[i] && (v[i] || $urandom_range(0, 3) != 0)) begin
          v[i] = 1'b1;
          d[i] = sbuf[i][head[i] % 64];
        end else begin
          v[i] = 1'b0;
          d[i] = fill_ones ? 9'h1FF : 9'($urandom);
        end
        if (v[i] && r[i]) begin
          model_accept(i, int'(d[i] & 9'((1 << DB[i]) - 1)), cyc + 1);
          head[i]++;
        end
      end
    end
  end

  task automatic wait_fall(input int i, output int t0);
    int n;
    n = 0;
    while (tx[i] !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    chk($sformatf("fall_wait%0d", i), 16'(n < 3000), 16'd1);
    t0 = cyc;
  endtask

  task automatic capture(input int i, input int len, output logic [11:0] bits, output int t0);
    bits = '0;
    wait_fall(i, t0);
    repeat (DIV / 2) @(negedge clk);
    bits[0] = tx[i];
    for (int b = 1; b < len; b++) begin
      repeat (DIV) @(negedge clk);
      bits[b] = tx[i];
    end
  endtask

  task automatic wait_idle();
    int n;
    bit idle;
    n = 0;
    do begin
      @(negedge clk); #1;
      idle = 1'b1;
      for (int i = 0; i < NI; i++)
        if (head[i] != tail[i] || cyc < next_free[i] + 2) idle = 1'b0;
      n++;
    end while (!idle && n < 6000);
    chk("idle_wait", 16'(idle), 16'd1);
  endtask

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic [11:0] bits;
    int         len;
  } vec_t;

  initial begin
    vec_t tbl [8];
    logic [11:0] got;
    int t0, t1;

    tbl[0] = '{0, 9'h055, 12'h2AA, 10};
    tbl[1] = '{1, 9'h007, 12'h60E, 11};
    tbl[2] = '{2, 9'h007, 12'h40E, 11};
    tbl[3] = '{3, 9'h07F, 12'h3FE, 10};
    tbl[4] = '{0, 9'h000, 12'h200, 10};
    tbl[5] = '{1, 9'h000, 12'h400, 11};
    tbl[6] = '{2, 9'h000, 12'h600, 11};
    tbl[7] = '{3, 9'h001, 12'h302, 10};

    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < MAXC; c++) exp_vec[i][c] = 4'b1001;
      next_free[i] = 0; last_done[i] = -1; head[i] = 0; tail[i] = 0;
      v[i] = 1'b0; d[i] = '0;
    end
    fill_ones = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", 16'(tx), 16'hF);
    chk("rst_ready", 16'(r), 16'hF);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Directed frames; idle data is all ones, so a post-handshake change would show.
    for (int n = 0; n < 8; n++) begin
      push(tbl[n].inst, tbl[n].data);
      capture(tbl[n].inst, tbl[n].len, got, t0);
      chk($sformatf("tbl%0d_bits", n), 16'(got), 16'(tbl[n].bits));
      repeat (DIV) @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_done", n), 16'(last_done[tbl[n].inst] - t0), 16'(tbl[n].len * DIV - 1));
    end

    // Back-to-back: second start bit directly follows the first frame's done clock.
    push(0, 9'h0A5);
    push(0, 9'h03C);
    capture(0, 10, got, t0);
    chk("b2b_first", 16'(got), 16'h34A);
    capture(0, 10, got, t1);
    chk("b2b_second", 16'(got), 16'h278);
    chk("b2b_gap", 16'(t1 - t0), 16'd100);
    chk("b2b_done", 16'(last_done[0] - t0), 16'd99);
    wait_idle();

    // Reset in the middle of data bit 3 (a 0 bit for 0xA5), then a clean frame.
    push(0, 9'h0A5);
    wait_fall(0, t0);
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    chk("pre_rst_tx", 16'(tx[0]), 16'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_tx", 16'(tx[0]), 16'd1);
    chk("mid_rst_ready", 16'(r[0]), 16'd1);
    chk("mid_rst_busy", 16'(busy[0]), 16'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    push(0, 9'h081);
    capture(0, 10, got, t0);
    chk("post_rst_frame", 16'(got), 16'h302);
    wait_idle();

    // Random traffic on all four configurations against the schedule model.
    fill_ones = 1'b0;
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int i = 0; i < NI; i++) begin
        int nb;
        nb = $urandom_range(0, 3);
        for (int j = 0; j < nb; j++) push(i, 9'($urandom));
      end
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
